// File: rtl/down_counter_mod.sv
// Loadable modulo down-counter with zero flag and registered terminal-count pulse.
// AUTO_RELOAD selects wrap-to-all-ones or reload-from-last-load at zero.
module down_counter_mod #(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             zero,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("down_counter_mod: WIDTH must be in 2..16");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             tc_q, tc_d;
  logic             at_zero;

  assign at_zero = (cnt_q == '0);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    rl_d  = rl_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = din;
      rl_d  = din;
    end else if (en) begin
      if (at_zero) begin
        // Arrival at zero was already flagged by the 1 -> 0 step; the wrap itself is silent.
        cnt_d = AUTO_RELOAD ? rl_q : '1;
      end else begin
        cnt_d = cnt_q - 1'b1;
        tc_d  = (cnt_q == WIDTH'(1));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
      rl_q  <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rl_q  <= rl_d;
      tc_q  <= tc_d;
    end
  end

  assign q    = cnt_q;
  assign qb   = ~cnt_q;
  assign zero = at_zero;
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter_mod.sv
// Scoreboard bench: one wrapping and one auto-reload counter share stimulus; an
// integer reference model queues expectations, a monitor pops and compares after each edge.
module tb_down_counter_mod;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         load;
  logic [W-1:0] din;

  logic [W-1:0] q_w, qb_w, q_r, qb_r;
  logic         zero_w, tc_w, zero_r, tc_r;

  down_counter_mod #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut_wrap (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din),
    .q(q_w), .qb(qb_w), .zero(zero_w), .tc(tc_w)
  );

  down_counter_mod #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut_rld (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din),
    .q(q_r), .qb(qb_r), .zero(zero_r), .tc(tc_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    q_w;
    int    tc_w;
    int    q_r;
    int    tc_r;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 wraps to all-ones, index 1 reloads.
  int m_q[2];
  int m_rl[2];
  int m_tc[2];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i]  = 0;
      m_rl[i] = 0;
      m_tc[i] = 0;
    end
  endtask

  task automatic model_edge(input bit ld, input bit e, input int d);
    for (int i = 0; i < 2; i++) begin
      if (ld) begin
        m_q[i]  = d;
        m_rl[i] = d;
        m_tc[i] = 0;
      end else if (e) begin
        if (m_q[i] == 0) begin
          m_q[i]  = (i == 1) ? m_rl[i] : MAXV;
          m_tc[i] = 0;
        end else begin
          m_tc[i] = (m_q[i] == 1) ? 1 : 0;
          m_q[i]  = m_q[i] - 1;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag, input int eqw, input int etw,
                             input int eqr, input int etr);
    check({tag, ".x"}, int'($isunknown({q_w, qb_w, zero_w, tc_w, q_r, qb_r, zero_r, tc_r})), 0);
    check({tag, ".w.q"},    int'(q_w),    eqw);
    check({tag, ".w.qb"},   int'(qb_w),   MAXV ^ eqw);
    check({tag, ".w.zero"}, int'(zero_w), (eqw == 0) ? 1 : 0);
    check({tag, ".w.tc"},   int'(tc_w),   etw);
    check({tag, ".r.q"},    int'(q_r),    eqr);
    check({tag, ".r.qb"},   int'(qb_r),   MAXV ^ eqr);
    check({tag, ".r.zero"}, int'(zero_r), (eqr == 0) ? 1 : 0);
    check({tag, ".r.tc"},   int'(tc_r),   etr);
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    e.q_w  = m_q[0];
    e.tc_w = m_tc[0];
    e.q_r  = m_q[1];
    e.tc_r = m_tc[1];
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, predict, then let the rising edge happen.
  task automatic step(input bit c, input bit ld, input bit e, input int d, input string tag);
    @(negedge clk);
    clr  = c;
    load = ld;
    en   = e;
    din  = W'(d);
    if (c) model_edge(ld, e, d);
    else   model_reset();
    push_expect(tag);
    @(posedge clk);
  endtask

  // As step, but with a short clr pulse between edges; outputs must clear at once.
  task automatic step_pulse(input bit ld, input bit e, input int d, input string tag);
    @(negedge clk);
    load = ld;
    en   = e;
    din  = W'(d);
    #1 clr = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"}, m_q[0], m_tc[0], m_q[1], m_tc[1]);
    #1 clr = 1'b1;
    model_edge(ld, e, d);
    push_expect(tag);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all(e.tag, e.q_w, e.tc_w, e.q_r, e.tc_r);
      end
    end
  end

  initial begin : stimulus
    clr  = 1'b0;
    en   = 1'b1;
    load = 1'b1;
    din  = W'(9);
    model_reset();
    #1;
    compare_all("rst_now", m_q[0], m_tc[0], m_q[1], m_tc[1]);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 9, "rst_hold");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 0, "rst_idle");

    step(1'b1, 1'b1, 1'b0, 3, "load3");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 0, "count3");

    step(1'b1, 1'b1, 1'b0, 2, "load2");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 0, "reload2");

    step(1'b1, 1'b1, 1'b0, 5, "load5");
    step(1'b1, 1'b1, 1'b1, 12, "prio");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, "hold12");

    step(1'b1, 1'b1, 1'b0, 2, "load2b");
    step(1'b1, 1'b0, 1'b1, 0, "to1");
    step_pulse(1'b0, 1'b1, 0, "midrst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 0, "post_rst");

    step(1'b1, 1'b1, 1'b0, 0, "load0");
    step(1'b1, 1'b0, 1'b1, 0, "wrap0");
    step(1'b1, 1'b0, 1'b0, 0, "idle0");

    for (int i = 0; i < 400; i++) begin
      bit ld, e;
      int d;
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = int'($urandom_range(0, MAXV));
      if ($urandom_range(0, 99) < 2) step_pulse(ld, e, d, "rnd_rst");
      else                           step(1'b1, ld, e, d, "rnd");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
